// File: rtl/axi4_arb2.sv
// axi4_arb2: two-master AXI4 arbiter, one outstanding burst at a time, regenerated wlast.
// Define AXI4ARB_RR_EN for round-robin master selection; default is fixed priority to master 0.
module axi4_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_awaddr_i,
  input  logic [7:0]          m0_awlen_i,
  input  logic                m0_awvalid_i,
  output logic                m0_awready_o,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  input  logic                m0_wlast_i,
  input  logic                m0_wvalid_i,
  output logic                m0_wready_o,
  output logic                m0_bvalid_o,
  input  logic                m0_bready_i,
  input  logic [ADDR_W-1:0]   m0_araddr_i,
  input  logic [7:0]          m0_arlen_i,
  input  logic                m0_arvalid_i,
  output logic                m0_arready_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rlast_o,
  output logic                m0_rvalid_o,
  input  logic                m0_rready_i,
  input  logic [ADDR_W-1:0]   m1_awaddr_i,
  input  logic [7:0]          m1_awlen_i,
  input  logic                m1_awvalid_i,
  output logic                m1_awready_o,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  input  logic                m1_wlast_i,
  input  logic                m1_wvalid_i,
  output logic                m1_wready_o,
  output logic                m1_bvalid_o,
  input  logic                m1_bready_i,
  input  logic [ADDR_W-1:0]   m1_araddr_i,
  input  logic [7:0]          m1_arlen_i,
  input  logic                m1_arvalid_i,
  output logic                m1_arready_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rlast_o,
  output logic                m1_rvalid_o,
  input  logic                m1_rready_i,
  output logic [ADDR_W-1:0]   s_awaddr_o,
  output logic [7:0]          s_awlen_o,
  output logic [1:0]          s_awburst_o,
  output logic                s_awvalid_o,
  input  logic                s_awready_i,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  output logic                s_wlast_o,
  output logic                s_wvalid_o,
  input  logic                s_wready_i,
  input  logic                s_bvalid_i,
  output logic                s_bready_o,
  output logic [ADDR_W-1:0]   s_araddr_o,
  output logic [7:0]          s_arlen_o,
  output logic [1:0]          s_arburst_o,
  output logic                s_arvalid_o,
  input  logic                s_arready_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_rlast_i,
  input  logic                s_rvalid_i,
  output logic                s_rready_o,
  output logic                grant_o,
  output logic                busy_o
);
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    AW   = 6'b000010,
    W    = 6'b000100,
    B    = 6'b001000,
    AR   = 6'b010000,
    R    = 6'b100000
  } state_t;
  state_t      state_q;
  logic        grant_q;
  logic [8:0]  wcnt_q;
  logic        req0, req1, sel;
  logic        in_aw, in_w, in_b, in_ar, in_r;
  logic        unused_wlast;
  assign unused_wlast = m0_wlast_i ^ m1_wlast_i;
  assign req0 = m0_awvalid_i | m0_arvalid_i;
  assign req1 = m1_awvalid_i | m1_arvalid_i;
`ifdef AXI4ARB_RR_EN
  // prio_q starts at master 0 so the first contended grant goes to m0, then alternates
  logic prio_q;
  assign sel = (req0 & req1) ? prio_q : req1;
  always_ff @(posedge clk)
    if (rst) prio_q <= 1'b0;
    else if (state_q == IDLE && (req0 | req1)) prio_q <= ~sel;
`else
  assign sel = ~req0;
`endif
  assign in_aw = state_q == AW;
  assign in_w  = state_q == W;
  assign in_b  = state_q == B;
  assign in_ar = state_q == AR;
  assign in_r  = state_q == R;
  assign grant_o = grant_q;
  assign busy_o  = state_q != IDLE;
  assign s_awaddr_o  = grant_q ? m1_awaddr_i : m0_awaddr_i;
  assign s_awlen_o   = grant_q ? m1_awlen_i : m0_awlen_i;
  assign s_awburst_o = 2'b01;
  assign s_awvalid_o = in_aw & (grant_q ? m1_awvalid_i : m0_awvalid_i);
  assign s_wdata_o   = grant_q ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o   = grant_q ? m1_wstrb_i : m0_wstrb_i;
  assign s_wlast_o   = in_w & (wcnt_q == 9'd0);
  assign s_wvalid_o  = in_w & (grant_q ? m1_wvalid_i : m0_wvalid_i);
  assign s_bready_o  = in_b & (grant_q ? m1_bready_i : m0_bready_i);
  assign s_araddr_o  = grant_q ? m1_araddr_i : m0_araddr_i;
  assign s_arlen_o   = grant_q ? m1_arlen_i : m0_arlen_i;
  assign s_arburst_o = 2'b01;
  assign s_arvalid_o = in_ar & (grant_q ? m1_arvalid_i : m0_arvalid_i);
  assign s_rready_o  = in_r & (grant_q ? m1_rready_i : m0_rready_i);
  assign m0_awready_o = in_aw & ~grant_q & s_awready_i;
  assign m1_awready_o = in_aw & grant_q & s_awready_i;
  assign m0_wready_o  = in_w & ~grant_q & s_wready_i;
  assign m1_wready_o  = in_w & grant_q & s_wready_i;
  assign m0_bvalid_o  = in_b & ~grant_q & s_bvalid_i;
  assign m1_bvalid_o  = in_b & grant_q & s_bvalid_i;
  assign m0_arready_o = in_ar & ~grant_q & s_arready_i;
  assign m1_arready_o = in_ar & grant_q & s_arready_i;
  assign m0_rvalid_o  = in_r & ~grant_q & s_rvalid_i;
  assign m1_rvalid_o  = in_r & grant_q & s_rvalid_i;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign m0_rlast_o = s_rlast_i;
  assign m1_rlast_o = s_rlast_i;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      wcnt_q  <= 9'd0;
    end else
      case (state_q)
        IDLE: if (req0 | req1) begin
          grant_q <= sel;
          state_q <= (sel ? m1_awvalid_i : m0_awvalid_i) ? AW : AR;
        end
        AW: if (s_awvalid_o & s_awready_i) begin
          wcnt_q  <= {1'b0, s_awlen_o};
          state_q <= W;
        end
        W: if (s_wvalid_o & s_wready_i) begin
          if (wcnt_q == 9'd0) state_q <= B;
          else wcnt_q <= wcnt_q - 9'd1;
        end
        B:  if (s_bvalid_i & s_bready_o) state_q <= IDLE;
        AR: if (s_arvalid_o & s_arready_i) state_q <= R;
        R:  if (s_rvalid_i & s_rready_o & s_rlast_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule
